// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: a byte FIFO feeding a frame serializer whose
// format (5-8 data bits, optional parity, 1-2 stop bits, bit period) is latched per frame.
module uart_tx_buffered #(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic                        clock,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [7:0]                  wr_data,
  input  logic [1:0]                  data_length,
  input  logic [1:0]                  parity_type,
  input  logic                        stop_bits,
  input  logic [DIV_W-1:0]            baud_div,
  output logic                        data_out,
  output logic                        tx_active,
  output logic                        tx_done,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);

  // IDLE: wait/pop | START: line 0 | DATA: N bits LSB first | PARITY | STOP: 1 or 2 high bits
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [2:0]       bit_idx_q, bit_idx_d, last_bit_q, last_bit_d;
  logic             par_en_q, par_en_d, par_bit_q, par_bit_d;
  logic             two_stop_q, two_stop_d, stop_idx_q, stop_idx_d;
  logic             data_out_q, data_out_d, tx_active_q, tx_active_d, tx_done_q, tx_done_d;
  logic             push, pop;
  logic [7:0]       mask, head_masked;

  assign full      = (level_q == (AW+1)'(FIFO_DEPTH));
  assign empty     = (level_q == '0);
  assign level     = level_q;
  assign pop       = (state_q == S_IDLE) && !empty;
  assign push      = wr_en && (!full || pop);
  assign overflow  = wr_en && full && !pop;
  assign data_out  = data_out_q;
  assign tx_active = tx_active_q;
  assign tx_done   = tx_done_q;

  always_comb begin
    case (data_length)
      2'b00:   mask = 8'h1F;
      2'b01:   mask = 8'h3F;
      2'b10:   mask = 8'h7F;
      default: mask = 8'hFF;
    endcase
    head_masked = mem_q[rd_ptr_q] & mask;
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    shreg_d     = shreg_q;
    bit_idx_d   = bit_idx_q;
    last_bit_d  = last_bit_q;
    par_en_d    = par_en_q;
    par_bit_d   = par_bit_q;
    two_stop_d  = two_stop_q;
    stop_idx_d  = stop_idx_q;
    data_out_d  = data_out_q;
    tx_active_d = tx_active_q;
    tx_done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        data_out_d  = 1'b1;
        tx_active_d = 1'b0;
        if (pop) begin
          state_d     = S_START;
          data_out_d  = 1'b0;
          tx_active_d = 1'b1;
          cnt_d       = baud_div;
          div_d       = baud_div;
          shreg_d     = head_masked;
          bit_idx_d   = 3'd0;
          last_bit_d  = {1'b1, data_length};
          par_en_d    = parity_type[0] ^ parity_type[1];
          par_bit_d   = (^head_masked) ^ (parity_type == 2'b01);
          two_stop_d  = stop_bits;
          stop_idx_d  = 1'b0;
        end
      end
      default: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          cnt_d = div_q;
          case (state_q)
            S_START: begin
              state_d    = S_DATA;
              data_out_d = shreg_q[0];
            end
            S_DATA: begin
              if (bit_idx_q == last_bit_q) begin
                state_d    = par_en_q ? S_PARITY : S_STOP;
                data_out_d = par_en_q ? par_bit_q : 1'b1;
              end else begin
                bit_idx_d  = bit_idx_q + 3'd1;
                shreg_d    = shreg_q >> 1;
                data_out_d = shreg_q[1];
              end
            end
            S_PARITY: begin
              state_d    = S_STOP;
              data_out_d = 1'b1;
            end
            default: begin
              data_out_d = 1'b1;
              if (two_stop_q && !stop_idx_q) begin
                stop_idx_d = 1'b1;
              end else begin
                state_d     = S_IDLE;
                tx_active_d = 1'b0;
                tx_done_d   = 1'b1;
              end
            end
          endcase
        end
      end
    endcase
  end

  // Storage needs no reset: contents are only visible through the pointers.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      div_q       <= '0;
      shreg_q     <= '0;
      bit_idx_q   <= '0;
      last_bit_q  <= '0;
      par_en_q    <= 1'b0;
      par_bit_q   <= 1'b0;
      two_stop_q  <= 1'b0;
      stop_idx_q  <= 1'b0;
      data_out_q  <= 1'b1;
      tx_active_q <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      shreg_q     <= shreg_d;
      bit_idx_q   <= bit_idx_d;
      last_bit_q  <= last_bit_d;
      par_en_q    <= par_en_d;
      par_bit_q   <= par_bit_d;
      two_stop_q  <= two_stop_d;
      stop_idx_q  <= stop_idx_d;
      data_out_q  <= data_out_d;
      tx_active_q <= tx_active_d;
      tx_done_q   <= tx_done_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: table of single frames with hand-computed
// bit sequences, plus burst/overflow, mid-frame config change and mid-frame reset.
module tb_uart_tx_buffered;
  logic        clock = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic [1:0]  data_length;
  logic [1:0]  parity_type;
  logic        stop_bits;
  logic [15:0] baud_div;
  logic        data_out, tx_active, tx_done, full, empty, overflow;
  logic [3:0]  level;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  data;
    logic [1:0]  dl;
    logic [1:0]  pt;
    logic        sb;
    logic [15:0] div;
    int          nbits;
    logic [11:0] exp;   // bit i = i-th bit period on the line, START first
  } vec_t;

  vec_t vecs [6];

  uart_tx_buffered #(.FIFO_DEPTH(8), .DIV_W(16)) dut (
    .clock(clock), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .data_length(data_length), .parity_type(parity_type), .stop_bits(stop_bits),
    .baud_div(baud_div), .data_out(data_out), .tx_active(tx_active), .tx_done(tx_done),
    .full(full), .empty(empty), .level(level), .overflow(overflow)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required the bench to finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic check_stream(input logic [11:0] exp, input int nbits, input int per,
                              input int max_wait, input int chg_cycle,
                              input logic [15:0] chg_div, input string nm);
    int w;
    int bad_c;
    logic bad_v;
    w = 0;
    bad_c = -1;
    bad_v = 1'b0;
    while (tx_active !== 1'b1 && w < max_wait) begin
      @(negedge clock);
      w++;
    end
    checks++;
    if (tx_active !== 1'b1) begin
      errors++;
      $display("FAIL %s start: tx_active=%b after %0d cycles, required 1", nm, tx_active, w);
      return;
    end
    for (int c = 0; c < nbits * per; c++) begin
      if (c > 0) @(negedge clock);
      if (c == chg_cycle) baud_div = chg_div;
      if (bad_c < 0 && (data_out !== exp[c / per] || tx_active !== 1'b1 || tx_done !== 1'b0)) begin
        bad_c = c;
        bad_v = data_out;
      end
    end
    checks++;
    if (bad_c >= 0) begin
      errors++;
      $display("FAIL %s line: cycle %0d data_out=%b tx_active=%b, required data_out=%b active=1",
               nm, bad_c, bad_v, tx_active, exp[bad_c / per]);
    end
    @(negedge clock);
    chk({nm, " done"}, {29'd0, tx_done, tx_active, data_out}, 32'b101);
  endtask

  task automatic run_frame(input vec_t v, input string nm);
    @(negedge clock);
    data_length = v.dl;
    parity_type = v.pt;
    stop_bits   = v.sb;
    baud_div    = v.div;
    wr_data     = v.data;
    wr_en       = 1'b1;
    @(negedge clock);
    wr_en = 1'b0;
    chk({nm, " queued"}, {26'd0, level, tx_active, data_out}, {26'd0, 4'd1, 1'b0, 1'b1});
    check_stream(v.exp, v.nbits, int'(v.div) + 1, 1, -1, 16'd0, nm);
  endtask

  logic rec [104];
  int   ovf_cnt, ovf_n, done_cnt, max_lvl, bad_n, idx, k, j, tdone_bad;
  logic e;
  logic [7:0] b;

  initial begin
    vecs[0] = '{8'hA5, 2'd3, 2'd0, 1'b0, 16'd3, 10, 12'b00_1101001010};  // 8N1
    vecs[1] = '{8'hFF, 2'd2, 2'd2, 1'b1, 16'd0, 11, 12'b0_11111111110};  // 7E2, bit 7 ignored
    vecs[2] = '{8'hF6, 2'd0, 2'd1, 1'b0, 16'd1,  8, 12'b0000_10101100};  // 5O1, upper bits masked
    vecs[3] = '{8'hC5, 2'd1, 2'd3, 1'b1, 16'd2,  9, 12'b000_110001010};  // 6N2 (type 11 = none)
    vecs[4] = '{8'h3C, 2'd3, 2'd2, 1'b0, 16'd0, 11, 12'b0_10001111000};  // 8E1
    vecs[5] = '{8'h01, 2'd3, 2'd1, 1'b1, 16'd1, 12, 12'b110000000010};   // 8O2

    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00;
    data_length = 2'd3; parity_type = 2'd0; stop_bits = 1'b0; baud_div = 16'd0;
    @(negedge clock);
    @(negedge clock);
    chk("reset outputs", {23'd0, data_out, tx_active, tx_done, full, empty, overflow, level},
        {23'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0});
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back frames with a divisor change in the middle of the first.
    @(negedge clock);
    data_length = 2'd3; parity_type = 2'd0; stop_bits = 1'b0; baud_div = 16'd3;
    wr_data = 8'h55; wr_en = 1'b1;
    @(negedge clock);
    wr_data = 8'h0F;
    chk("b2b first queued", {27'd0, level, tx_active}, {27'd0, 4'd1, 1'b0});
    @(negedge clock);
    wr_en = 1'b0;
    chk("b2b push+pop level", {27'd0, level, tx_active}, {27'd0, 4'd1, 1'b1});
    check_stream(12'b00_1010101010, 10, 4, 0, 10, 16'd7, "b2b frame1 div3");
    check_stream(12'b00_1000011110, 10, 8, 1, -1, 16'd0, "b2b frame2 div8");
    chk("b2b drained", {27'd0, level, empty}, {27'd0, 4'd0, 1'b1});

    // Ten writes into an 8-deep FIFO while idle at one clock per bit.
    @(negedge clock);
    baud_div = 16'd0;
    ovf_cnt = 0; ovf_n = -1; done_cnt = 0; max_lvl = 0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          wr_data = 8'h10 + 8'(i);
          wr_en = 1'b1;
          @(negedge clock);
        end
        wr_en = 1'b0;
      end
      begin
        for (int n = 0; n < 104; n++) begin
          #2;
          rec[n] = data_out;
          if (overflow) begin ovf_cnt++; ovf_n = n; end
          if (tx_done) done_cnt++;
          if (int'(level) > max_lvl) max_lvl = int'(level);
          @(negedge clock);
        end
      end
    join
    bad_n = -1;
    for (int n = 0; n < 104; n++) begin
      e = 1'b1;
      if (n >= 2) begin
        idx = n - 2; k = idx / 11; j = idx % 11;
        if (k < 9) begin
          b = 8'h10 + 8'(k);
          if (j == 0) e = 1'b0;
          else if (j <= 8) e = b[j-1];
        end
      end
      if (bad_n < 0 && rec[n] !== e) bad_n = n;
    end
    chk("burst line first bad sample", bad_n, -1);
    chk("burst overflow count", ovf_cnt, 1);
    chk("burst overflow cycle", ovf_n, 9);
    chk("burst max level", max_lvl, 8);
    chk("burst tx_done count", done_cnt, 9);
    chk("burst drained", {27'd0, empty, level}, {27'd0, 1'b1, 4'd0});

    // Reset in the middle of DATA with three entries queued.
    data_length = 2'd3; parity_type = 2'd0; stop_bits = 1'b0; baud_div = 16'd3;
    wr_data = 8'h11; wr_en = 1'b1;
    @(negedge clock); wr_data = 8'h22;
    @(negedge clock); wr_data = 8'h33;
    @(negedge clock); wr_data = 8'h44;
    @(negedge clock); wr_en = 1'b0;
    repeat (4) @(negedge clock);
    chk("pre-reset busy", {27'd0, level, tx_active}, {27'd0, 4'd3, 1'b1});
    rst = 1'b1;
    #1;
    chk("mid-frame reset", {25'd0, data_out, tx_active, tx_done, empty, level},
        {25'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0});
    tdone_bad = 0;
    repeat (3) begin
      @(negedge clock);
      if (tx_done !== 1'b0 || data_out !== 1'b1) tdone_bad++;
    end
    chk("held reset quiet", tdone_bad, 0);
    @(negedge clock);
    rst = 1'b0;
    wr_data = vecs[0].data; baud_div = vecs[0].div; wr_en = 1'b1;
    @(negedge clock);
    wr_en = 1'b0;
    chk("write on first edge after reset", {28'd0, level}, {28'd0, 4'd1});
    check_stream(vecs[0].exp, vecs[0].nbits, 4, 1, -1, 16'd0, "post-reset frame");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_buffered.md
UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 Parameter FIFO_DEPTH, default 8; TX buffer entries; power of two, 2..64.
REQ-002 Parameter DIV_W, default 16; width of the baud divisor.
REQ-003 clock  input  1  single system clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 wr_en  input  1  push wr_data into the FIFO this cycle.
REQ-006 wr_data  input  8  byte to transmit; only the low N bits are used.
REQ-007 data_length  input  2  N data bits: 00=5, 01=6, 10=7, 11=8.
REQ-008 parity_type  input  2  00=none, 01=odd, 10=even, 11=none.
REQ-009 stop_bits  input  1  0=one stop bit, 1=two stop bits.
REQ-010 baud_div  input  DIV_W  bit period = baud_div+1 clocks.
REQ-011 data_out  output  1  serial line; idle high.
REQ-012 tx_active  output  1  high while a frame is on the line (START..STOP).
REQ-013 tx_done  output  1  one-cycle pulse at end of each frame.
REQ-014 full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-015 empty  output  1  FIFO holds zero entries.
REQ-016 level  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-017 overflow  output  1  one-cycle pulse when a write is dropped.

Function
REQ-018 The FIFO shall accept a write when wr_en=1 and (full=0 or a pop occurs the same cycle).
REQ-019 If wr_en=1 while full=1 and there is no same-cycle pop, the block shall drop the write, keep FIFO contents unchanged, and pulse overflow.
REQ-020 Read and write pointers shall wrap modulo FIFO_DEPTH; level shall change by +1, -1 or 0 for push-only, pop-only or both.
REQ-021 The FSM shall have states IDLE, START, DATA, PARITY, STOP.
REQ-022 From IDLE with empty=0, the FSM shall pop one entry, latch data_length, parity_type, stop_bits and baud_div, and enter START on the next edge.
REQ-023 Latched configuration shall stay fixed for the whole frame; input changes mid-frame shall affect only the next frame.
REQ-024 Each of START, every DATA bit, PARITY and every STOP bit shall drive data_out for exactly latched baud_div+1 clocks.
REQ-025 START shall drive 0; DATA shall send N bits LSB first; STOP shall drive 1 for 1 or 2 bit periods.
REQ-026 PARITY shall be entered only for types 01 or 10; for other types, DATA shall go directly to STOP.
REQ-027 The parity bit shall be XOR of the N sent bits for even parity, and its inverse for odd parity; unused upper bits shall be excluded.
REQ-028 On the last clock of the final stop bit, the FSM shall return to IDLE and tx_done shall be high for that one cycle.
REQ-029 Back-to-back frames shall have exactly one idle-high clock between the final stop bit and the next start bit.
REQ-030 tx_active shall be 1 in START, DATA, PARITY and STOP, and 0 in IDLE.
REQ-031 The bit-period counter shall count down from the latched baud_div; baud_div=0 shall give one clock per bit.

Reset
REQ-032 While rst=1, the block shall set FSM=IDLE, pointers and level=0, and clear all counters.
REQ-033 While rst=1, outputs shall be data_out=1, tx_active=0, tx_done=0, full=0, empty=1, overflow=0.
REQ-034 Reset asserted mid-frame shall abort the frame immediately, set data_out=1, and discard all buffered entries.
REQ-035 After rst falls, wr_en on the first clock edge shall be accepted.

Verification
REQ-036 8N1, baud_div=3, write 0xA5: data_out = 0, then 1,0,1,0,0,1,0,1, then 1, with each bit lasting 4 clocks; tx_done pulses at clock 40 after START entry.
REQ-037 7 bits, even parity, 2 stop bits, baud_div=0, write 0xFF: data_out = 0, seven 1s, parity 1, then 1,1; bit 7 is ignored.
REQ-038 FIFO_DEPTH=8, write 10 bytes in consecutive cycles while idle: the first pops at once, full asserts, one overflow pulse occurs, and 9 frames are sent in order.
REQ-039 Write 2 bytes back-to-back: the second start bit begins exactly 1 clock after the first tx_done.
REQ-040 Change baud_div from 3 to 7 mid-frame: the current frame keeps 4 clocks per bit, and the next frame uses 8.
REQ-041 Assert rst during DATA with 3 queued entries: data_out=1 and empty=1 at once, with no tx_done; a new write after reset transmits normally.
